root_result_streamer: RTL and testbench

Serialises one decoding round's result into a stream of 32-bit words over a valid/ready interface: a header word carrying the test ID, one word per processing unit carrying its root coordinates, and a trailer word carrying status. It sits on the result side of the stage controller, takes `roots`, `result_valid`, `deadlock`, `iteration_counter` and `cycle_counter`, and produces words in the same layout as the golden output files. Host link logic and off-chip dump paths consume it.

---
 rtl/root_result_streamer.sv | 174 +++++++++++++++++
 tb/tb_root_result_streamer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/root_result_streamer.sv
// root_result_streamer
//   Serialises one decoding round's result into a stream of 32-bit words:
//   a header (test ID), one word per processing unit with its root
//   coordinates, and a trailer carrying deadlock / iteration / cycle status.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   result_valid        decoder result ready (level)
//   deadlock            decoder deadlock (level)
//   roots               per-PU root, PU n at [n*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   iteration_counter   iterations used (low 8 bits reported)
//   cycle_counter       cycles used (low 16 bits reported)
//   out_data/out_valid  stream word and its valid
//   out_ready           consumer accepts
//   busy                a frame is captured or in flight (registered)
//   drop_count          saturating count of triggers ignored while busy
//   fsm_state           debug view of the FSM state (0 IDLE, 1 HEADER,
//                       2 ROOTS, 3 TRAILER)
//
// Stream handshake: a word transfers on a rising clk edge where
// out_valid & out_ready. Once out_valid is high, out_valid and out_data hold
// until that transfer; only reset can withdraw a word.

module root_result_streamer #(
  parameter int CODE_DISTANCE_X         = 3,
  parameter int CODE_DISTANCE_Z         = 2,
  parameter int MEASUREMENT_ROUNDS      = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                          CODE_DISTANCE_X : CODE_DISTANCE_Z,
  parameter int PU_COUNT                = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  parameter int PER_DIMENSION_WIDTH     = $clog2(MEASUREMENT_ROUNDS),
  parameter int ADDRESS_WIDTH           = 3 * PER_DIMENSION_WIDTH,
  parameter int ITERATION_COUNTER_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                result_valid,
  input  logic                                deadlock,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots,
  input  logic [ITERATION_COUNTER_WIDTH-1:0]  iteration_counter,
  input  logic [31:0]                         cycle_counter,
  output logic [31:0]                         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic [7:0]                          drop_count,
  output logic [1:0]                          fsm_state
);

  localparam int IDX_W = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PU_COUNT - 1);
  localparam int PDW = PER_DIMENSION_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_ROOTS   = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t                              state;
  logic                                trig_q;
  logic [31:0]                         test_id;
  logic [IDX_W-1:0]                    idx;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots_cap;
  logic                                deadlock_cap;
  logic [7:0]                          iter_cap;
  logic [15:0]                         cyc_cap;

  logic                                trig;
  logic                                trig_edge;
  logic                                hs;
  logic [IDX_W-1:0]                    next_idx;
  logic [ADDRESS_WIDTH-1:0]            root_sel;
  logic [31:0]                         root_word;
  logic [31:0]                         trailer_word;

  assign trig      = result_valid | deadlock;
  assign trig_edge = trig & ~trig_q;
  assign hs        = out_valid & out_ready;
  assign fsm_state = state;

  assign trailer_word = {deadlock_cap, 7'b0, iter_cap, cyc_cap};

  // out_data is registered, so on each handshake we load the word that will
  // be presented next: from HEADER that is root 0, from ROOTS it is idx+1.
  assign next_idx = (state == S_ROOTS) ? idx + IDX_W'(1) : '0;

  always_comb begin
    root_sel = '0;
    for (int n = 0; n < PU_COUNT; n++) begin
      if (next_idx == IDX_W'(n)) begin
        root_sel = roots_cap[n*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
    // Address is packed {k,i,j}; each coordinate lands in its own byte lane.
    root_word = '0;
    root_word[PDW-1:0]   = root_sel[PDW-1:0];
    root_word[8 +: PDW]  = root_sel[PDW +: PDW];
    root_word[16 +: PDW] = root_sel[2*PDW +: PDW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      trig_q       <= 1'b0;
      test_id      <= '0;
      idx          <= '0;
      roots_cap    <= '0;
      deadlock_cap <= 1'b0;
      iter_cap     <= '0;
      cyc_cap      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      drop_count   <= '0;
    end else begin
      trig_q <= trig;

      // Any trigger edge outside IDLE is lost, including one coinciding with
      // the trailer handshake (state is still TRAILER on that edge).
      if (trig_edge && (state != S_IDLE) && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (trig_edge) begin
            roots_cap    <= roots;
            deadlock_cap <= deadlock;
            iter_cap     <= 8'(iteration_counter);
            cyc_cap      <= cycle_counter[15:0];
            idx          <= '0;
            out_data     <= test_id;
            out_valid    <= 1'b1;
            busy         <= 1'b1;
            state        <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (hs) begin
            out_data <= root_word;
            state    <= S_ROOTS;
          end
        end
        S_ROOTS: begin
          if (hs) begin
            if (idx == LAST_IDX) begin
              out_data <= trailer_word;
              state    <= S_TRAILER;
            end else begin
              out_data <= root_word;
              idx      <= next_idx;
            end
          end
        end
        S_TRAILER: begin
          if (hs) begin
            test_id   <= test_id + 32'd1;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_root_result_streamer.sv
// Testbench for root_result_streamer with default parameters (d=3 lattice:
// X=3, Z=2, 3 rounds, 18 PUs, 2-bit coordinates).
module tb_root_result_streamer;

  localparam int DX  = 3;
  localparam int DZ  = 2;
  localparam int PU  = 18;
  localparam int AW  = 6;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic              rv;
  logic              dl;
  logic [AW*PU-1:0]  roots_in;
  logic [7:0]        iter_in;
  logic [31:0]       cyc_in;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [7:0]        drop_count;
  logic [1:0]        fsm_state;

  // 0: ready always, 1: random 50 %, 2: ready held low
  logic [1:0]        ready_mode;
  logic              rnd_bit;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign out_ready = (ready_mode == 2'd2) ? 1'b0 :
                     (ready_mode == 2'd1) ? rnd_bit : 1'b1;

  root_result_streamer dut (
    .clk               (clk),
    .reset             (reset),
    .result_valid      (rv),
    .deadlock          (dl),
    .roots             (roots_in),
    .iteration_counter (iter_in),
    .cycle_counter     (cyc_in),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .drop_count        (drop_count),
    .fsm_state         (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] tid_m;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_root_word(input logic [AW-1:0] r);
    // r = {k,i,j}, 2 bits each -> j in byte 0, i in byte 1, k in byte 2
    return {8'h00, 6'b0, r[5:4], 6'b0, r[3:2], 6'b0, r[1:0]};
  endfunction

  task automatic push_frame(input logic [AW*PU-1:0] r, input logic d,
                            input logic [7:0] it, input logic [31:0] cy);
    exp_q.push_back(tid_m);
    for (int n = 0; n < PU; n++) exp_q.push_back(model_root_word(r[n*AW +: AW]));
    exp_q.push_back({d, 7'b0, it, cy[15:0]});
    tid_m = tid_m + 32'd1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic        stall_pend;
  logic [31:0] stall_data;

  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_word", 32'(out_valid), 32'd0);
        else check("word", out_data, exp_q.pop_front());
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_own_roots();
    int k, i, j, rem;
    for (int n = 0; n < PU; n++) begin
      k   = n / (DX * DZ);
      rem = n % (DX * DZ);
      i   = rem / DZ;
      j   = rem % DZ;
      roots_in[n*AW +: AW] = {2'(k), 2'(i), 2'(j)};
    end
  endtask

  task automatic scramble();
    for (int n = 0; n < PU; n++) roots_in[n*AW +: AW] = 6'($urandom_range(0, 63));
    iter_in = 8'($urandom);
    cyc_in  = $urandom;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tid_m = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    tid_m = '0;
    reset = 1'b1;
    rv = 1'b0;
    dl = 1'b0;
    roots_in = '0;
    iter_in = '0;
    cyc_in = '0;
    ready_mode = 2'd0;
    stall_pend = 1'b0;
    stall_data = '0;

    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;
    tick();

    // Single frame, own-address roots, latency and frame length.
    set_own_roots();
    iter_in = 8'h2A;
    cyc_in  = 32'h0001BEEF;
    rv = 1'b1;
    push_frame(roots_in, 1'b0, iter_in, cyc_in);
    tick();                                // trigger edge T
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_header", out_data, 32'd0);
    rv = 1'b0;
    scramble();                            // capture isolation
    repeat (19) tick();
    check("busy_last", 32'(busy), 32'd1);
    tick();                                // T+20: trailer accepted
    check("busy_end", 32'(busy), 32'd0);
    check("valid_end", 32'(out_valid), 32'd0);
    check("q_frame1", 32'(exp_q.size()), 32'd0);

    // Deadlock frame.
    scramble();
    dl = 1'b1;
    iter_in = 8'd5;
    cyc_in  = 32'h00AB1234;
    push_frame(roots_in, 1'b1, iter_in, cyc_in);
    tick();
    dl = 1'b0;
    scramble();
    wait_done();

    // Random ready stalls.
    ready_mode = 2'd1;
    for (int f = 0; f < 3; f++) begin
      scramble();
      rv = 1'b1;
      push_frame(roots_in, 1'b0, iter_in, cyc_in);
      tick();
      rv = 1'b0;
      scramble();
      wait_done();
    end
    ready_mode = 2'd0;

    // Drops at cycle 3 and at the trailer handshake; next trigger captured.
    do_reset();
    set_own_roots();
    rv = 1'b1;
    push_frame(roots_in, 1'b0, iter_in, cyc_in);
    tick();                                // T
    rv = 1'b0;
    tick();                                // T+1
    tick();                                // T+2
    rv = 1'b1;
    tick();                                // T+3: dropped
    check("drop_one", 32'(drop_count), 32'd1);
    rv = 1'b0;
    repeat (16) tick();                    // T+19
    rv = 1'b1;
    tick();                                // T+20: trailer handshake + drop
    check("drop_two", 32'(drop_count), 32'd2);
    check("drop_idle", 32'(busy), 32'd0);
    rv = 1'b0;
    tick();
    scramble();
    rv = 1'b1;
    push_frame(roots_in, 1'b0, iter_in, cyc_in);
    tick();
    check("recap_valid", 32'(out_valid), 32'd1);
    check("recap_header", out_data, 32'd1);
    rv = 1'b0;
    wait_done();
    check("drop_kept", 32'(drop_count), 32'd2);

    // Reset in the middle of ROOTS (idx 7).
    scramble();
    rv = 1'b1;
    push_frame(roots_in, 1'b0, iter_in, cyc_in);
    tick();                                // T
    rv = 1'b0;
    tick();
    rv = 1'b1;
    tick();                                // T+2: dropped
    rv = 1'b0;
    check("mid_drop", 32'(drop_count), 32'd3);
    repeat (6) tick();                     // T+8: presenting root 7
    check("mid_state", 32'(fsm_state), 32'd2);
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_drop", 32'(drop_count), 32'd0);
    check("abort_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;
    tid_m = '0;
    tick();
    scramble();
    rv = 1'b1;
    push_frame(roots_in, 1'b0, iter_in, cyc_in);
    tick();
    check("post_rst_header", out_data, 32'd0);
    rv = 1'b0;
    wait_done();

    // result_valid held high through reset deassert: exactly one frame.
    reset = 1'b1;
    rv = 1'b1;
    exp_q.delete();
    tid_m = '0;
    scramble();
    tick();
    tick();
    push_frame(roots_in, 1'b0, iter_in, cyc_in);
    reset = 1'b0;
    tick();
    check("held_valid", 32'(out_valid), 32'd1);
    wait_done();
    repeat (30) tick();
    check("held_busy", 32'(busy), 32'd0);
    check("held_drop", 32'(drop_count), 32'd0);
    rv = 1'b0;
    tick();

    // Drop counter saturation with the consumer stalled.
    ready_mode = 2'd2;
    scramble();
    rv = 1'b1;
    push_frame(roots_in, 1'b0, iter_in, cyc_in);
    tick();
    rv = 1'b0;
    tick();
    for (int p = 1; p <= 300; p++) begin
      rv = 1'b1;
      tick();
      rv = 1'b0;
      tick();
      if (p == 254) check("sat_254", 32'(drop_count), 32'd254);
      if (p == 255) check("sat_255", 32'(drop_count), 32'd255);
    end
    check("sat_300", 32'(drop_count), 32'd255);
    ready_mode = 2'd0;
    wait_done();
    check("sat_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
